// File: rtl/cmp_pipe.sv
// cmp_pipe: two-stage valid/ready signed/unsigned comparator with saturating masked hit counter
module cmp_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_flags,
  input  logic [7:0]       hit_mask,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] hit_cnt
);
  logic             s1_v_q, sg_q, out_valid_q, stall, hit, eq, lt;
  logic [WIDTH-1:0] a_q, b_q;
  logic [7:0]       flags_q, flags_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign stall     = out_valid_q & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = out_valid_q;
  assign out_flags = flags_q;
  assign hit_cnt   = cnt_q;
  always_comb begin
    eq      = a_q == b_q;
    lt      = sg_q ? ($signed(a_q) < $signed(b_q)) : (a_q < b_q);
    flags_d = {eq, ~eq, lt, lt | eq, ~(lt | eq), ~lt, a_q === b_q, a_q !== b_q};
    hit     = out_valid_q & out_ready & (|(flags_q & hit_mask));
    cnt_d   = clr_cnt ? '0 : (hit && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q      <= 1'b0;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sg_q        <= 1'b0;
      flags_q     <= '0;
      cnt_q       <= '0;
    end else begin
      if (!stall) begin
        s1_v_q      <= in_valid;
        a_q         <= in_a;
        b_q         <= in_b;
        sg_q        <= in_signed;
        out_valid_q <= s1_v_q;
        flags_q     <= flags_d;
      end
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_cmp_pipe.sv
// tb_cmp_pipe: scoreboard bench for cmp_pipe (WIDTH=8/CNT_W=2 main instance, WIDTH=1 side instance)
module tb_cmp_pipe;
  logic       clk = 0, rst = 1;
  logic       in_valid = 0, in_ready, in_signed = 0, out_valid, out_ready = 1, clr_cnt = 0;
  logic [7:0] in_a = 0, in_b = 0, out_flags, hit_mask = 0;
  logic [1:0] hit_cnt;
  logic       w1_v = 0, w1_rdy, w1_a = 0, w1_b = 0, w1_s = 0, w1_ov, w1_clr = 0;
  logic [7:0] w1_flags;
  logic [15:0] w1_cnt;
  int checks = 0, errors = 0;
  logic [7:0] sb[$];
  logic [1:0] exp_cnt = 0;
  logic       acc = 0, prev_stall = 0, hs;
  logic [7:0] held = 0, e;
  int         seq[5] = '{1, 2, 3, 3, 3};
  int         nb, cyc;
  always #5 clk = ~clk;
  cmp_pipe #(.WIDTH(8), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_signed(in_signed), .out_valid(out_valid), .out_ready(out_ready), .out_flags(out_flags),
    .hit_mask(hit_mask), .clr_cnt(clr_cnt), .hit_cnt(hit_cnt)
  );
  cmp_pipe #(.WIDTH(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .in_valid(w1_v), .in_ready(w1_rdy), .in_a(w1_a), .in_b(w1_b),
    .in_signed(w1_s), .out_valid(w1_ov), .out_ready(1'b1), .out_flags(w1_flags),
    .hit_mask(8'h00), .clr_cnt(w1_clr), .hit_cnt(w1_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
    int  ia = (s && a[7]) ? int'(a) - 256 : int'(a);
    int  ib = (s && b[7]) ? int'(b) - 256 : int'(b);
    logic q = a == b, l = ia < ib;
    return {q, !q, l, l || q, !(l || q), !l, q, !q};
  endfunction
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s);
    int n = 0;
    in_a = a;
    in_b = b;
    in_signed = s;
    in_valid = 1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 0;
  endtask
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      exp_cnt = 0;
      acc = 0;
      prev_stall = 0;
    end else begin
      chk("hit_cnt", 32'(hit_cnt), 32'(exp_cnt));
      if (prev_stall && out_valid) chk("flags_hold", 32'(out_flags), 32'(held));
      if (out_valid && !out_ready) chk("in_ready_stall", 32'(in_ready), 0);
      acc = in_valid && in_ready;
      if (acc) sb.push_back(model(in_a, in_b, in_signed));
      hs = out_valid && out_ready;
      if (hs) begin
        if (sb.size() == 0) chk("sb_unexpected", 1, 0);
        else begin
          e = sb.pop_front();
          chk("flags", 32'(out_flags), 32'(e));
          chk("inv_eq", 32'(out_flags[7] ^ out_flags[6]), 1);
          chk("inv_lt", 32'(out_flags[5] ^ out_flags[2]), 1);
          chk("inv_le", 32'(out_flags[4] ^ out_flags[3]), 1);
          chk("inv_lelt", 32'(out_flags[4]), 32'(out_flags[5] | out_flags[7]));
        end
      end
      if (clr_cnt) exp_cnt = 0;
      else if (hs && (out_flags & hit_mask) != 0 && exp_cnt != 2'd3) exp_cnt = exp_cnt + 1;
      prev_stall = out_valid && !out_ready;
      held = out_flags;
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_flags", 32'(out_flags), 0);
    chk("rst_cnt", 32'(hit_cnt), 0);
    chk("rst_ready", 32'(in_ready), 1);
    send(8'd5, 8'd5, 0);
    chk("lat1_valid", 32'(out_valid), 0);
    @(posedge clk); #1;
    chk("lat2_valid", 32'(out_valid), 1);
    chk("t1_flags", 32'(out_flags), 32'h96);
    send(8'hFF, 8'h01, 0);
    send(8'hFF, 8'h01, 1);
    chk("t2_uns", 32'(out_flags), 32'h4D);
    @(posedge clk); #1;
    chk("t2_sgn", 32'(out_flags), 32'h71);
    w1_v = 1; w1_a = 1; w1_b = 0; w1_s = 1;
    @(posedge clk); #1 w1_s = 0;
    @(posedge clk); #1 w1_v = 0;
    chk("w1_sgn", 32'(w1_flags), 32'h71);
    chk("w1_valid", 32'(w1_ov), 1);
    @(posedge clk); #1;
    chk("w1_uns", 32'(w1_flags), 32'h4D);
    fork
      for (int i = 0; i < 4; i++) send(8'($urandom), 8'($urandom), 1'($urandom));
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1;
      end
    join
    repeat (4) @(posedge clk); #1;
    chk("t3_drain", sb.size(), 0);
    hit_mask = 8'h80;
    for (int i = 0; i < 5; i++) begin
      send(8'd7, 8'd7, 0);
      repeat (2) @(posedge clk); #1;
      chk("t4_sat", 32'(hit_cnt), 32'(seq[i]));
    end
    send(8'd7, 8'd7, 0);
    @(posedge clk); #1;
    chk("t4_hitcyc", 32'(out_valid), 1);
    clr_cnt = 1;
    @(posedge clk); #1 clr_cnt = 0;
    chk("t4_clr", 32'(hit_cnt), 0);
    hit_mask = 8'hFF;
    send(8'd1, 8'd2, 0);
    repeat (2) @(posedge clk); #1;
    chk("t5_pre", 32'(hit_cnt), 1);
    out_ready = 0;
    send(8'd3, 8'd3, 0);
    @(posedge clk); #1;
    chk("t5_stalled", 32'(out_valid), 1);
    rst = 1;
    @(posedge clk); #1 rst = 0;
    chk("t5_valid", 32'(out_valid), 0);
    chk("t5_cnt", 32'(hit_cnt), 0);
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("t5_gone", 32'(out_valid), 0);
    end
    nb = 0;
    cyc = 0;
    while (nb < 10000 && cyc < 40000) begin
      if (acc) nb++;
      if (!in_valid || acc) begin
        in_valid = $urandom_range(0, 3) != 0;
        in_a = 8'($urandom);
        in_b = ($urandom_range(0, 7) == 0) ? in_a : 8'($urandom);
        in_signed = 1'($urandom);
      end
      out_ready = $urandom_range(0, 3) != 0;
      hit_mask = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      clr_cnt = $urandom_range(0, 31) == 0;
      @(posedge clk); #1;
      cyc++;
    end
    chk("t6_beats", 32'(nb >= 10000), 1);
    in_valid = 0;
    clr_cnt = 0;
    out_ready = 1;
    repeat (4) @(posedge clk); #1;
    chk("t6_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
